// File: rtl/mgmt_arbiter_pkg.sv
// Shared definitions for the management-bus arbiter.
// Holds the FSM state encoding, master index constants and the minimum
// width of the optional timeout counter.
package mgmt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT_RX = 2'd2
  } state_t;

  // Master indices: the core is master 0, the debug port is master 1.
  localparam logic M_CORE  = 1'b0;
  localparam logic M_DEBUG = 1'b1;

  // The timeout counter is never narrower than this.
  localparam int MIN_CNT_W = 8;

endpackage

// File: rtl/mgmt_arbiter.sv
// mgmt_arbiter: two-master round-robin arbiter onto a shared management bus.
// Latency: one IDLE cycle for arbitration, then s_req follows the owner; acks and read data pass through combinationally.
// Backpressure: a waiting master holds mN_req until its ack; it is never dropped and is served next.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   m0_* / m1_*                core (0) and debug (1) master ports: req/adr/rwn/wen/txd in,
//                              ack/rxe/rxd out
//   s_req/adr/rwn/wen/txd      shared bus towards the slaves
//   s_ack/rxe/rxd              OR-combined slave responses
//   busy                       a transaction is owned (GRANT or WAIT_RX)
//   err                        one-cycle pulse on timeout abort
//
// Build option: define MGMT_TIMEOUT_EN to abort owned transactions after
// TIMEOUT cycles without a response; otherwise the arbiter waits forever
// and err is tied 0.
module mgmt_arbiter
  import mgmt_arbiter_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic [31:0] m0_adr,
  input  logic        m0_rwn,
  input  logic [1:0]  m0_wen,
  input  logic [31:0] m0_txd,
  output logic        m0_ack,
  output logic        m0_rxe,
  output logic [31:0] m0_rxd,

  input  logic        m1_req,
  input  logic [31:0] m1_adr,
  input  logic        m1_rwn,
  input  logic [1:0]  m1_wen,
  input  logic [31:0] m1_txd,
  output logic        m1_ack,
  output logic        m1_rxe,
  output logic [31:0] m1_rxd,

  output logic        s_req,
  output logic [31:0] s_adr,
  output logic        s_rwn,
  output logic [1:0]  s_wen,
  output logic [31:0] s_txd,
  input  logic        s_ack,
  input  logic        s_rxe,
  input  logic [31:0] s_rxd,

  output logic        busy,
  output logic        err
);

  state_t r_state;
  logic   r_owner;  // master holding the bus while busy
  logic   r_pref;   // master favoured on the next tie (the one not served last)

  // Owner's request fields, selected by the latched owner.
  logic        w_own_req;
  logic [31:0] w_own_adr;
  logic        w_own_rwn;
  logic [1:0]  w_own_wen;
  logic [31:0] w_own_txd;

  assign w_own_req = (r_owner == M_DEBUG) ? m1_req : m0_req;
  assign w_own_adr = (r_owner == M_DEBUG) ? m1_adr : m0_adr;
  assign w_own_rwn = (r_owner == M_DEBUG) ? m1_rwn : m0_rwn;
  assign w_own_wen = (r_owner == M_DEBUG) ? m1_wen : m0_wen;
  assign w_own_txd = (r_owner == M_DEBUG) ? m1_txd : m0_txd;

  logic w_granted, w_waiting, w_owned;
  assign w_granted = (r_state == ST_GRANT);
  assign w_waiting = (r_state == ST_WAIT_RX);
  assign w_owned   = w_granted | w_waiting;

  // A GRANT cycle only counts while the owner still requests; a dropped
  // request is an abandon and must not produce an ack even if s_ack is high.
  logic w_grant_ok, w_ack, w_rx_now;
  assign w_grant_ok = w_granted & w_own_req;
  assign w_ack      = w_grant_ok & s_ack;
  assign w_rx_now   = (w_ack & w_own_rwn & s_rxe) | (w_waiting & s_rxe);

  // Abort terms: ack still owed (GRANT) and read data owed (read in GRANT,
  // or anything in WAIT_RX).
  logic w_abort, w_abort_ack, w_abort_rx;

`ifdef MGMT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > MIN_CNT_W) ? $clog2(TIMEOUT + 1) : MIN_CNT_W;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  // Counter reads 0 on the first GRANT cycle, so the abort lands on the
  // TIMEOUT-th owned cycle. '>=' keeps a read that was acked late in GRANT
  // from slipping past the limit in WAIT_RX. A response on that same cycle
  // wins over the abort.
  assign w_abort     = w_owned && (r_cnt >= TMO_LIM) &&
                       ((w_grant_ok && !s_ack) || (w_waiting && !s_rxe));
  assign w_abort_ack = w_abort & w_granted;
  assign w_abort_rx  = w_abort & (w_waiting | w_own_rwn);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT == 0) ^ ERR_DATA[0];

  assign w_abort     = 1'b0;
  assign w_abort_ack = 1'b0;
  assign w_abort_rx  = 1'b0;
`endif

  // Transaction finished this cycle (normally or by abort).
  logic w_done;
  assign w_done = (w_ack & (~w_own_rwn | s_rxe)) | (w_waiting & s_rxe) | w_abort;

  // Master-side response, before demux to the owner.
  logic        w_mack, w_mrxe;
  logic [31:0] w_mrxd;
  assign w_mack = w_ack | w_abort_ack;
  assign w_mrxe = w_rx_now | w_abort_rx;
  assign w_mrxd = w_rx_now   ? s_rxd :
                  w_abort_rx ? ERR_DATA : 32'h0;

  // Acks and read data must reach the master in the slave's response cycle,
  // so these are decoded from registered state rather than registered.
  assign m0_ack = w_mack & (r_owner == M_CORE);
  assign m0_rxe = w_mrxe & (r_owner == M_CORE);
  assign m0_rxd = (r_owner == M_CORE) ? w_mrxd : 32'h0;
  assign m1_ack = w_mack & (r_owner == M_DEBUG);
  assign m1_rxe = w_mrxe & (r_owner == M_DEBUG);
  assign m1_rxd = (r_owner == M_DEBUG) ? w_mrxd : 32'h0;

  assign s_req = w_grant_ok;
  assign s_adr = w_owned ? w_own_adr : 32'h0;
  assign s_rwn = w_owned ? w_own_rwn : 1'b0;
  assign s_wen = w_owned ? w_own_wen : 2'b00;
  assign s_txd = w_owned ? w_own_txd : 32'h0;

  assign busy = w_owned;
  assign err  = w_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= M_CORE;
      r_pref  <= M_CORE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            r_owner <= (m0_req && m1_req) ? r_pref : m1_req;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_own_req) begin
            // Abandon: no ack, fairness pointer untouched.
            r_state <= ST_IDLE;
          end else if (w_done) begin
            r_state <= ST_IDLE;
            r_pref  <= ~r_owner;
          end else if (w_ack) begin
            r_state <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_pref  <= ~r_owner;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
